// File: rtl/hart_memory_arbiter_pkg.sv
// Shared definitions for the hart memory arbiter: FSM state encoding,
// requester slot assignment and width helpers used by the top and the picker.
package hart_memory_arbiter_pkg;

  // Arbiter FSM states (2-bit encoding shared with older tooling).
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_RESP = 2'd2;
  localparam logic [1:0] DRAIN     = 2'd3;

  // Fixed requester slots on the arbiter.
  localparam int FETCH = 0;
  localparam int LOAD  = 1;
  localparam int STORE = 2;

  localparam int DEFAULT_NUM_REQUESTERS = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int index_width(input int num_requesters);
    return (num_requesters > 1) ? $clog2(num_requesters) : 1;
  endfunction

  // Width of the watchdog counter; must be able to hold the timeout value itself.
  function automatic int counter_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/hart_memory_arbiter_round_robin_picker.sv
// Combinational round-robin picker: returns the first requesting slot found
// when scanning upward from the pointer, wrapping modulo the requester count.
module hart_memory_arbiter_round_robin_picker
  import hart_memory_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = DEFAULT_NUM_REQUESTERS,
  parameter int INDEX_WIDTH    = index_width(DEFAULT_NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic [INDEX_WIDTH-1:0]    pointer,
  output logic [NUM_REQUESTERS-1:0] grant_onehot,
  output logic [INDEX_WIDTH-1:0]    grant_index,
  output logic                      any
);

  logic [NUM_REQUESTERS-1:0] rotated;
  logic [INDEX_WIDTH:0]      offset;
  logic [INDEX_WIDTH:0]      wrapped;

  // Rotate the request vector so the pointer slot sits at bit 0, take the lowest set bit, then map back.
  always_comb begin
    rotated = NUM_REQUESTERS'({request, request} >> pointer);
    offset  = '0;
    any     = 1'b0;
    for (int off = NUM_REQUESTERS - 1; off >= 0; off--) begin
      if (rotated[off]) begin
        offset = (INDEX_WIDTH + 1)'(off);
        any    = 1'b1;
      end
    end
    wrapped = {1'b0, pointer} + offset;
    if (wrapped >= (INDEX_WIDTH + 1)'(NUM_REQUESTERS)) begin
      wrapped = wrapped - (INDEX_WIDTH + 1)'(NUM_REQUESTERS);
    end
    grant_index  = wrapped[INDEX_WIDTH-1:0];
    grant_onehot = any ? (NUM_REQUESTERS'(1) << grant_index) : '0;
  end

endmodule

// File: rtl/hart_memory_arbiter.sv
// Shares the single memory-controller port among fetch, load and store.
// One transaction is in flight at a time: accept (IDLE), issue a registered
// request (ISSUE), wait for the response (WAIT_RESP), and, if the watchdog
// already answered with an error, swallow the late response (DRAIN).
module hart_memory_arbiter
  import hart_memory_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = DEFAULT_NUM_REQUESTERS,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                                clock,
  input  logic                                clear_n,
  input  logic [NUM_REQUESTERS-1:0]           req_valid,
  output logic [NUM_REQUESTERS-1:0]           req_ready,
  input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQUESTERS-1:0]           req_write,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_write_data,
  output logic [NUM_REQUESTERS-1:0]           resp_valid,
  output logic                                resp_error,
  output logic [DATA_WIDTH-1:0]               resp_read_data,
  output logic                                mem_valid,
  input  logic                                mem_ready,
  output logic [ADDRESS_WIDTH-1:0]            mem_address,
  output logic                                mem_write,
  output logic [DATA_WIDTH-1:0]               mem_write_data,
  input  logic                                mem_resp_valid,
  input  logic                                mem_resp_error,
  input  logic [DATA_WIDTH-1:0]               mem_resp_read_data,
  output logic                                mem_resp_ready,
  output logic                                busy
);

  localparam int INDEX_WIDTH = index_width(NUM_REQUESTERS);
  localparam int COUNT_WIDTH = counter_width(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX    = INDEX_WIDTH'(NUM_REQUESTERS - 1);

  logic [1:0]                state;
  logic [INDEX_WIDTH-1:0]    grant;
  logic [INDEX_WIDTH-1:0]    rr_pointer;
  logic [COUNT_WIDTH-1:0]    wait_count;
  logic [ADDRESS_WIDTH-1:0]  address_q;
  logic                      write_q;
  logic [DATA_WIDTH-1:0]     write_data_q;

  logic [NUM_REQUESTERS-1:0] pick_onehot;
  logic [INDEX_WIDTH-1:0]    pick_index;
  logic                      pick_any;
  logic                      complete;
  logic                      timeout_hit;
  logic [INDEX_WIDTH-1:0]    next_pointer;

  hart_memory_arbiter_round_robin_picker #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .INDEX_WIDTH    (INDEX_WIDTH)
  ) picker (
    .request      (req_valid),
    .pointer      (rr_pointer),
    .grant_onehot (pick_onehot),
    .grant_index  (pick_index),
    .any          (pick_any)
  );

  // Completion (real response) and watchdog expiry; a real response in the expiry cycle wins.
  always_comb begin
    complete     = mem_resp_valid &&
                   (((state == ISSUE) && mem_ready) || (state == WAIT_RESP));
    timeout_hit  = (TIMEOUT_CYCLES != 0) && (state == WAIT_RESP) &&
                   !mem_resp_valid && (wait_count == TIMEOUT_LIMIT);
    next_pointer = (grant == LAST_INDEX) ? '0 : grant + 1'b1;
  end

  // Requester-facing handshake and response routing; everything is quiet while reset is held.
  always_comb begin
    req_ready      = (clear_n && (state == IDLE)) ? pick_onehot : '0;
    resp_valid     = '0;
    resp_error     = 1'b0;
    resp_read_data = '0;
    if (complete) begin
      resp_valid     = NUM_REQUESTERS'(1) << grant;
      resp_error     = mem_resp_error;
      resp_read_data = mem_resp_read_data;
    end else if (timeout_hit) begin
      resp_valid = NUM_REQUESTERS'(1) << grant;
      resp_error = 1'b1;
    end
  end

  assign mem_valid      = (state == ISSUE);
  assign mem_address    = address_q;
  assign mem_write      = write_q;
  assign mem_write_data = write_data_q;
  assign mem_resp_ready = 1'b1;
  assign busy           = (state != IDLE);

  // Transaction FSM with request capture, watchdog counter and round-robin pointer update.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state        <= IDLE;
      grant        <= '0;
      rr_pointer   <= '0;
      wait_count   <= '0;
      address_q    <= '0;
      write_q      <= 1'b0;
      write_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            address_q    <= req_address[pick_index*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            write_q      <= req_write[pick_index];
            write_data_q <= req_write_data[pick_index*DATA_WIDTH +: DATA_WIDTH];
            grant        <= pick_index;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            if (mem_resp_valid) begin
              rr_pointer <= next_pointer;
              state      <= IDLE;
            end else begin
              wait_count <= '0;
              state      <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          wait_count <= wait_count + 1'b1;
          if (mem_resp_valid) begin
            rr_pointer <= next_pointer;
            state      <= IDLE;
          end else if (timeout_hit) begin
            rr_pointer <= next_pointer;
            state      <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_resp_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
